// File: rtl/twi_stage_sched.sv
// Stage/group sequencer for the radix-16 FFT datapath: issues one beat per butterfly group
// (bank, address, stage, twiddle index) and inserts a drain gap between stages.
module twi_stage_sched #(
  parameter int A_WIDTH   = 9,
  parameter int NUM_STAGE = 4,
  parameter int S_WIDTH   = 2,
  parameter int DRAIN     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  output logic               BN_out,
  output logic [A_WIDTH-1:0] MA_out,
  output logic [S_WIDTH-1:0] stage_out,
  output logic [A_WIDTH:0]   tw_idx,
  output logic               tw_en
);

  localparam int                 GW     = A_WIDTH + 1;
  localparam logic [GW-1:0]      G_LAST = '1;
  localparam logic [S_WIDTH-1:0] S_LAST = S_WIDTH'(NUM_STAGE - 1);
  localparam int                 DW     = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [DW-1:0]      D_LAST = DW'((DRAIN > 0) ? DRAIN - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  // Twiddle index: keep the group bits that still select a distinct twiddle at this
  // stage, scaled up by 16^S; zero once the stage consumes every group bit.
  function automatic logic [GW-1:0] tw_of(input logic [GW-1:0] g, input logic [S_WIDTH-1:0] s);
    int            sh;
    logic [GW-1:0] m;
    sh = 4 * int'(s);
    m  = '1;
    if (sh >= GW) return '0;
    m = m >> sh;
    return (g & m) << sh;
  endfunction

  state_t             r_state;
  logic [GW-1:0]      r_g;
  logic [S_WIDTH-1:0] r_s;
  logic [DW-1:0]      r_dcnt;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_bn;
  logic [A_WIDTH-1:0] r_ma;
  logic [S_WIDTH-1:0] r_stage;
  logic [GW-1:0]      r_tw;
  logic               r_twen;

  logic               w_acc;
  logic               w_g_last;
  logic               w_s_last;
  logic               w_d_last;
  logic               w_load;
  logic               w_fin;
  logic [GW-1:0]      w_ld_g;
  logic [S_WIDTH-1:0] w_ld_s;

  assign w_acc    = r_valid & out_ready;
  assign w_g_last = (r_g == G_LAST);
  assign w_s_last = (r_s == S_LAST);
  assign w_d_last = (r_dcnt == D_LAST);

  // Coordinates of the beat loaded next: next group in this stage, first group of
  // the next stage, or (from IDLE) the very first beat.
  always_comb begin
    w_ld_g = '0;
    w_ld_s = '0;
    if (r_state == ST_RUN && !w_g_last) begin
      w_ld_g = r_g + GW'(1);
      w_ld_s = r_s;
    end else if (r_state != ST_IDLE) begin
      w_ld_s = r_s + S_WIDTH'(1);
    end
  end

  always_comb begin
    w_load = 1'b0;
    w_fin  = 1'b0;
    case (r_state)
      ST_IDLE:  w_load = start;
      ST_RUN: begin
        w_load = w_acc & (!w_g_last | ((DRAIN == 0) & !w_s_last));
        w_fin  = w_acc & w_g_last & (DRAIN == 0) & w_s_last;
      end
      ST_DRAIN: begin
        w_load = w_d_last & !w_s_last;
        w_fin  = w_d_last & w_s_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_g     <= '0;
      r_s     <= '0;
      r_dcnt  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bn    <= 1'b0;
      r_ma    <= '0;
      r_stage <= '0;
      r_tw    <= '0;
      r_twen  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_acc && w_g_last && (DRAIN > 0)) begin
            r_state <= ST_DRAIN;
            r_valid <= 1'b0;
            r_dcnt  <= '0;
            r_g     <= '0;
          end
        end
        ST_DRAIN: r_dcnt  <= r_dcnt + DW'(1);
        ST_DONE:  r_state <= ST_IDLE;
        default: ;
      endcase
      if (w_load) begin
        r_state <= ST_RUN;
        r_valid <= 1'b1;
        r_busy  <= 1'b1;
        r_g     <= w_ld_g;
        r_s     <= w_ld_s;
        r_bn    <= ^w_ld_g;
        r_ma    <= w_ld_g[A_WIDTH:1];
        r_stage <= w_ld_s;
        r_tw    <= tw_of(w_ld_g, w_ld_s);
        r_twen  <= (w_ld_s != S_LAST);
      end
      if (w_fin) begin
        r_state <= ST_DONE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_g     <= '0;
        r_s     <= '0;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_valid;
  assign BN_out    = r_bn;
  assign MA_out    = r_ma;
  assign stage_out = r_stage;
  assign tw_idx    = r_tw;
  assign tw_en     = r_twen;

endmodule

// File: tb/tb_twi_stage_sched.sv
// Bench for twi_stage_sched: scoreboard of expected (stage, group) beats plus a table of
// hand-computed field vectors; a second instance covers DRAIN=0 with a single stage.
module tb_twi_stage_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst, start1, start2, rdy;
  logic       busy1, done1, v1, bn1, twen1;
  logic [8:0] ma1;
  logic [1:0] st1;
  logic [9:0] tw1;
  logic       busy2, done2, v2, bn2, twen2;
  logic [8:0] ma2;
  logic [0:0] st2;
  logic [9:0] tw2;

  twi_stage_sched #(.A_WIDTH(9), .NUM_STAGE(4), .S_WIDTH(2), .DRAIN(5)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .out_ready(rdy),
    .busy(busy1), .done(done1), .out_valid(v1), .BN_out(bn1), .MA_out(ma1),
    .stage_out(st1), .tw_idx(tw1), .tw_en(twen1));

  twi_stage_sched #(.A_WIDTH(9), .NUM_STAGE(1), .S_WIDTH(1), .DRAIN(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .out_ready(rdy),
    .busy(busy2), .done(done2), .out_valid(v2), .BN_out(bn2), .MA_out(ma2),
    .stage_out(st2), .tw_idx(tw2), .tw_en(twen2));

  typedef struct {int s; int g; int bn; int ma; int tw; int twen;} beat_t;

  beat_t sbq[$];
  beat_t tv[7];
  int    cap[4][1024];
  int    nvec = 0, nfail = 0;
  bit    sel, stalled, have_acc, done_seen;
  int    held, last_acc, last_acc_st, t0, done_cyc, done_busy, rdy_mode, exp_gap;

  function automatic int pk(int s, int twen, int bn, int ma, int tw);
    return (s << 24) | (twen << 20) | (bn << 19) | (ma << 10) | tw;
  endfunction

  // Reference beat: parity of G, upper G bits, and the twiddle index built bit by bit
  // as G shifted up by 4*S with everything above bit 9 discarded.
  function automatic beat_t model(int s, int g, int ns);
    beat_t b;
    b.s = s; b.g = g; b.bn = 0; b.tw = 0;
    for (int i = 0; i < 10; i++) b.bn = b.bn ^ ((g >> i) & 1);
    b.ma = g >> 1;
    for (int i = 0; i < 10; i++)
      if (i >= 4 * s) b.tw = b.tw | (((g >> (i - 4 * s)) & 1) << i);
    b.twen = (s != ns - 1) ? 1 : 0;
    return b;
  endfunction

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    int a, st;
    bit v, bz, dn;
    @(negedge clk);
    if (sel) begin
      v = v2; bz = busy2; dn = done2; st = int'(st2);
      a = pk(st, int'(twen2), int'(bn2), int'(ma2), int'(tw2));
    end else begin
      v = v1; bz = busy1; dn = done1; st = int'(st1);
      a = pk(st, int'(twen1), int'(bn1), int'(ma1), int'(tw1));
    end
    if (v) begin
      if (stalled) chk("stall_hold", a, held);
      chk("busy_in_run", int'(bz), 1);
      if (have_acc && !stalled && st != last_acc_st)
        chk("drain_gap", cyc - last_acc - 1, exp_gap);
    end
    rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (v && rdy) begin
      if (sbq.size() == 0) chk("extra_beat", a, -1);
      else begin
        beat_t e;
        e = sbq.pop_front();
        chk("beat", a, pk(e.s, e.twen, e.bn, e.ma, e.tw));
        if (!sel) cap[e.s][e.g] = a;
      end
      last_acc = cyc; last_acc_st = st; have_acc = 1'b1; stalled = 1'b0;
    end else begin
      stalled = v;
      held    = a;
    end
    if (dn) begin
      done_seen = 1'b1; done_cyc = cyc; done_busy = int'(bz);
    end
  endtask

  task automatic do_start(int ns);
    sbq.delete();
    for (int s = 0; s < ns; s++)
      for (int g = 0; g < 1024; g++) sbq.push_back(model(s, g, ns));
    have_acc = 1'b0; stalled = 1'b0; done_seen = 1'b0;
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    t0 = cyc;
    tick();
    start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic run_done(int budget, int exp_done, bit pokes);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      if (pokes && (n == 100 || n == 1026)) start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n++;
    end
    if (!done_seen) chk("timeout_waiting_done", 0, 1);
    else begin
      if (exp_done >= 0) chk("done_cycle", done_cyc - t0, exp_done);
      chk("done_after_last_accept", done_cyc - last_acc, exp_gap + 1);
      chk("busy_at_done", done_busy, 0);
      chk("scoreboard_empty", sbq.size(), 0);
    end
  endtask

  initial begin
    tv[0] = '{1, 'h3FF, 0, 'h1FF, 'h3F0, 1};
    tv[1] = '{2, 'h3FF, 0, 'h1FF, 'h300, 1};
    tv[2] = '{3, 'h3FF, 0, 'h1FF, 'h000, 0};
    tv[3] = '{3, 'h001, 1, 'h000, 'h000, 0};
    tv[4] = '{0, 'h001, 1, 'h000, 'h001, 1};
    tv[5] = '{1, 'h012, 0, 'h009, 'h120, 1};
    tv[6] = '{2, 'h2A5, 1, 'h152, 'h100, 1};

    sel = 1'b0; rdy = 1'b1; rdy_mode = 0; exp_gap = 5;
    stalled = 1'b0; have_acc = 1'b0; done_seen = 1'b0;
    rst = 1'b1; start1 = 1'b1; start2 = 1'b1;
    repeat (3) begin
      tick();
      chk("reset_outs_dut1", int'({busy1, done1, v1, bn1, ma1, st1, tw1, twen1}), 0);
      chk("reset_outs_dut2", int'({busy2, done2, v2, bn2, ma2, st2, tw2, twen2}), 0);
    end
    rst = 1'b0; start1 = 1'b0; start2 = 1'b0;
    tick();

    // Reset in the middle of a run aborts without a done pulse.
    do_start(4);
    repeat (50) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_valid", int'(v1), 0);
    chk("midrun_rst_busy", int'(busy1), 0);
    repeat (3) begin
      tick();
      chk("midrun_rst_no_done", int'({done1, v1}), 0);
    end

    // Full run with out_ready=1, start pulses while busy, then start during DONE.
    do_start(4);
    run_done(6000, 4117, 1'b1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("done_one_cycle", int'(done1), 0);
    chk("start_in_done_ignored", int'({v1, busy1}), 0);
    repeat (2) begin
      tick();
      chk("idle_after_done", int'({v1, busy1, done1}), 0);
    end

    for (int i = 0; i < 7; i++)
      chk($sformatf("fields_s%0d_g%03h", tv[i].s, tv[i].g), cap[tv[i].s][tv[i].g],
          pk(tv[i].s, tv[i].twen, tv[i].bn, tv[i].ma, tv[i].tw));

    // Random backpressure: new run accepted from IDLE.
    rdy_mode = 1;
    do_start(4);
    run_done(20000, -1, 1'b0);
    tick();

    // DRAIN=0, single stage.
    sel = 1'b1; rdy_mode = 0; exp_gap = 0;
    do_start(1);
    run_done(3000, 1025, 1'b0);
    tick();
    rdy_mode = 1;
    do_start(1);
    run_done(5000, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
